// File: rtl/div_measure.sv
// div_measure: recovers period and high time of a divided clock sampled in the clk domain,
// with lock detection on a stable ratio and error pulses on out-of-range periods or stalls.
module div_measure #(
    parameter int WIDTH    = 4,
    parameter int MAX_N    = 15,
    parameter int CNT_W    = 6,
    parameter int TIMEOUT  = 63,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] n_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             locked,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
    state_t state, state_d;
    logic s1, s2, s3;
    logic [CNT_W-1:0] per_cnt, high_cnt, match, match_d, match_inc;
    logic [WIDTH-1:0] n_d, high_d;
    logic valid_d, err_d, rise, act, in_range, same, timeout, lock_hit;

    assign rise      = s2 & ~s3;
    assign act       = rise && state != IDLE;
    assign in_range  = per_cnt >= CNT_W'(2) && per_cnt <= CNT_W'(MAX_N);
    assign same      = per_cnt[WIDTH-1:0] == n_out;
    assign timeout   = state != IDLE && !rise && per_cnt == CNT_W'(TIMEOUT);
    // match saturates at LOCK_CNT so a long lock never wraps the counter
    assign match_inc = !same ? CNT_W'(1) : match == CNT_W'(LOCK_CNT) ? match : match + 1'b1;
    assign lock_hit  = match_inc >= CNT_W'(LOCK_CNT);
    assign locked    = state == LOCKED;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = timeout ? IDLE : !rise ? state : (act && in_range && lock_hit) ? LOCKED : MEASURE;
    end

    always_comb begin
        valid_d = act && in_range;
        err_d   = (act && !in_range) || timeout;
        match_d = timeout ? '0 : !act ? match : in_range ? match_inc : '0;
        n_d     = timeout ? '0 : valid_d ? per_cnt[WIDTH-1:0] : n_out;
        high_d  = timeout ? '0 : valid_d ? high_cnt[WIDTH-1:0] : high_out;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            {s1, s2, s3} <= '0;
            per_cnt      <= '0;
            high_cnt     <= '0;
            match        <= '0;
            n_out        <= '0;
            high_out     <= '0;
            valid        <= 1'b0;
            err          <= 1'b0;
        end else begin
            s1       <= sig_in;
            s2       <= s1;
            s3       <= s2;
            per_cnt  <= rise ? CNT_W'(1) : per_cnt == CNT_W'(TIMEOUT) ? per_cnt : per_cnt + 1'b1;
            high_cnt <= rise ? CNT_W'(1) : (s2 && high_cnt != '1) ? high_cnt + 1'b1 : high_cnt;
            match    <= match_d;
            n_out    <= n_d;
            high_out <= high_d;
            valid    <= valid_d;
            err      <= err_d;
        end
    end
endmodule

// File: tb/tb_div_measure.sv
// tb_div_measure: directed plus randomized waveforms, checked every cycle against a
// timestamp-based model of edges, periods and high times.
module tb_div_measure;
    logic clk = 0, reset = 0, sig_in = 0;
    logic [3:0] n_out, high_out;
    logic valid, locked, err;
    int total = 0, bad = 0;

    div_measure dut (.clk(clk), .reset(reset), .sig_in(sig_in), .n_out(n_out),
                     .high_out(high_out), .valid(valid), .locked(locked), .err(err));

    always #5 clk = ~clk;

    // model state: sig_in sampled at every edge, indexed by edge number
    bit h[$];
    int e = 0, last_rst = -1, e0 = 0, match = 0, en = 0, eh = 0;
    bit active = 0, lk = 0, ev = 0, ee = 0;

    task check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, e, got, exp);
        end
    endtask

    // s2 just before edge k holds the sig_in captured two edges earlier, unless a reset intervened
    function automatic bit s2b(input int k);
        return (k - 2 > last_rst && k - 2 >= 0) ? h[k-2] : 1'b0;
    endfunction

    task model_step(input bit r, input bit s);
        int per, hc;
        h.push_back(s);
        ev = 0;
        ee = 0;
        if (!r) begin
            last_rst = e; active = 0; lk = 0; match = 0; en = 0; eh = 0;
        end else if (s2b(e) && !s2b(e - 1)) begin
            if (active) begin
                per = (e - e0 > 63) ? 63 : e - e0;
                if (per >= 2 && per <= 15) begin
                    hc = 0;
                    for (int k = e0; k < e; k++) hc += int'(s2b(k));
                    ev = 1;
                    match = (per == en) ? match + 1 : 1;
                    en = per;
                    eh = hc;
                    lk = match >= 2;
                end else begin
                    ee = 1; match = 0; lk = 0;
                end
            end
            active = 1;
            e0 = e;
        end else if (active && e - e0 >= 63) begin
            ee = 1; lk = 0; en = 0; eh = 0; match = 0; active = 0;
        end
    endtask

    task tick(input bit r, input bit s);
        reset = r;
        sig_in = s;
        @(posedge clk);
        model_step(r, s);
        #1;
        check("valid", int'(valid), int'(ev));
        check("err", int'(err), int'(ee));
        check("locked", int'(locked), int'(lk));
        check("n_out", int'(n_out), en);
        check("high_out", int'(high_out), eh);
        e++;
    endtask

    task wave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < per; i++) tick(1, i < hi);
    endtask

    task hold(input bit s, input int n);
        for (int i = 0; i < n; i++) tick(1, s);
    endtask

    task do_reset(input bit s, input int n);
        for (int i = 0; i < n; i++) tick(0, s);
    endtask

    initial begin
        #2;
        do_reset(0, 3);
        wave(4, 2, 6);
        wave(5, 2, 4);
        wave(7, 3, 4);
        wave(20, 5, 4);
        wave(15, 7, 4);
        wave(16, 8, 3);
        wave(2, 1, 6);
        wave(3, 1, 5);
        hold(0, 70);
        wave(3, 1, 4);
        do_reset(1, 3);
        wave(6, 3, 4);
        wave(8, 4, 4);
        do_reset(0, 1);
        wave(8, 4, 5);
        hold(1, 70);
        wave(5, 3, 3);
        for (int seg = 0; seg < 40; seg++) begin
            int p, hi, sel;
            sel = int'($urandom_range(0, 9));
            p = int'($urandom_range(2, 20));
            hi = int'($urandom_range(1, p - 1));
            if (sel == 0) hold(1'($urandom_range(0, 1)), int'($urandom_range(40, 75)));
            else if (sel == 1) do_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            else wave(p, hi, int'($urandom_range(1, 5)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_measure.md
Name: div_measure

Overview:
- Measurement-side counterpart of the team's programmable clock divider.
- Takes a divided clock generated from `clk` and recovers its division ratio `n` (period in `clk` cycles) and its high time.
- Flags lock when the ratio is stable, and flags error when the input stalls or is out of range.
- Used in self-check and bring-up logic to confirm that a divider is producing the programmed ratio.

Parameters:
- `WIDTH`, 4: width of `n_out`/`high_out`; matches the divider's 4-bit `n`.
- `MAX_N`, 15: largest legal period; a captured period in [2, `MAX_N`] is in range.
- `CNT_W`, 6: internal period/high counter width; must satisfy 2**`CNT_W`-1 > `MAX_N`.
- `TIMEOUT`, 63: `per_cnt` value at which a missing edge is declared; must be ≤ 2**`CNT_W`-1.
- `LOCK_CNT`, 2: number of consecutive identical in-range periods needed to assert `locked`.

Ports:
- `clk`, input, 1: single clock; all logic on posedge.
- `reset`, input, 1: synchronous, active-low reset.
- `sig_in`, input, 1: divided clock under measurement; passes through a 3-flop sample chain (`s1`, `s2`, `s3`).
- `n_out`, output, `WIDTH`: last captured in-range period in `clk` cycles.
- `high_out`, output, `WIDTH`: number of cycles `s2` was high during that period.
- `valid`, output, 1: one-cycle pulse; `n_out`/`high_out` were updated.
- `locked`, output, 1: level; ratio stable.
- `err`, output, 1: one-cycle pulse; out-of-range period or timeout.

Behaviour:
- Reset (`reset`=0 at posedge): `s1`/`s2`/`s3`=0, state=IDLE, `per_cnt`=0, `high_cnt`=0, match count=0, `n_out`=0, `high_out`=0, `valid`=0, `locked`=0, `err`=0.
  - Reset has priority over all other events, including reset asserted mid-measurement.
- Edge detect: `rise` = `s2` & ~`s3`.
  - `sig_in` first sampled high at edge k gives `rise` during cycle k+1..k+2; it is acted on at edge k+2.
  - `valid`/`err` are visible after edge k+2, i.e. 3 edges of latency.
- `per_cnt` is reloaded to 1 on each acted-on rise, then increments by 1 per cycle and saturates at `TIMEOUT`.
- `high_cnt` is reloaded to 1 on rise, then increments in each cycle where `s2`=1.
- Captured period = `per_cnt` value at the next rise; captured high time = `high_cnt` at that rise.
  - Minimum possible period is 2.
  - Both values are truncated to `WIDTH` bits only after the range check passes.
- States:
  - IDLE: wait for `rise`, then go to MEASURE and reload the counters. No `valid` on this first edge.
    - If `sig_in` is already high at reset release, the first rise is still only a start event.
  - MEASURE, on `rise`:
    - Period in [2, `MAX_N`]: load `n_out`/`high_out`, pulse `valid`.
      - Period equals the previous capture: match count +1; otherwise match count = 1.
      - Match count reaching `LOCK_CNT`: go to LOCKED and set `locked`=1 in the same update as that `valid`.
    - Period out of range: pulse `err`, match count = 0, stay in MEASURE. `n_out`/`high_out` hold.
  - LOCKED, on `rise`:
    - Same in-range period: pulse `valid`, stay.
    - Different in-range period: pulse `valid` with the new values, clear `locked`, match count = 1, go to MEASURE.
    - Out of range: pulse `err`, clear `locked`, match count = 0, go to MEASURE.
  - Any state except IDLE, `per_cnt` = `TIMEOUT` with no `rise` this cycle: pulse `err`, clear `locked`, `n_out`/`high_out` = 0, match count = 0, go to IDLE.
    - Covers a stuck-high or stuck-low input.
  - `rise` and timeout in the same cycle: `rise` wins. The period equals `TIMEOUT` and is out of range, so `err` pulses and the state goes to MEASURE with counters reloaded.
- `valid` and `err` are never high in the same cycle.
- The sample chain keeps running in every state.

Test Plan:
- Divider-style input, period 4, high 2, continuous, after reset release:
  - No `valid` on the first rise.
  - `valid` with `n_out`=4, `high_out`=2 at every later rise.
  - `locked`=1 together with the 2nd `valid`.
- Input period 5, high 2: `n_out`=5, `high_out`=2, `locked` after 2 captures. Then switch to period 7, high 3:
  - First capture gives `valid`, `n_out`=7, `high_out`=3, `locked`=0.
  - Next capture gives `locked`=1.
- Input period 20 (> `MAX_N`): `err` pulse at each rise, `valid` never asserts, `n_out` holds its prior value, `locked`=0.
- Locked at period 3, then `sig_in` held low:
  - 63 cycles after the last rise's reload: `err` pulse, `locked`=0, `n_out`=`high_out`=0, state IDLE.
  - Restart at period 3: first rise gives no `valid`; second rise gives `n_out`=3.
- `sig_in` high through reset, `reset` released: first detected rise produces nothing; next rise (period 6, high 3) gives `valid`, `n_out`=6.
- `reset`=0 for one cycle while locked at period 8: next cycle all outputs 0 and state IDLE; `locked` returns after 3 further rises.
